// File: rtl/mod_serial_pkg.sv
// Shared types and helpers for the bit-serial divisibility checker.
package mod_serial_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Width needed to hold any remainder modulo divisor.
  function automatic int unsigned rem_width(input int unsigned divisor);
    return $clog2(divisor);
  endfunction

endpackage

// File: rtl/mod_serial_step.sv
// One compare-subtract step of MSB-first modulo reduction: r' = (2r + b) mod DIVISOR.
module mod_serial_step #(
  parameter int unsigned DIVISOR = 7,
  parameter int unsigned RW      = 3
) (
  input  logic [RW-1:0] r,
  input  logic          b,
  output logic [RW-1:0] r_next
);

  localparam logic [RW:0] DivW = (RW+1)'(DIVISOR);

  logic [RW:0] t;
  logic [RW:0] diff;

  always_comb begin
    t    = {r, b};
    diff = t - DivW;
    // r < DIVISOR keeps t < 2*DIVISOR, so one subtraction suffices.
    r_next = (t >= DivW) ? diff[RW-1:0] : t[RW-1:0];
  end

endmodule

// File: rtl/mod_serial.sv
// Bit-serial divisibility checker; MOD_SERIAL_REM_OUT_EN adds the rem output port.
module mod_serial
  import mod_serial_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIVISOR = 7,
  localparam int unsigned RW     = rem_width(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src,
  input  logic             src_valid,
  output logic             ready,
  output logic             res,
  output logic             res_valid
`ifdef MOD_SERIAL_REM_OUT_EN
  ,
  output logic [RW-1:0]    rem
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("mod_serial: DIVISOR must be in 2..255");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("mod_serial: WIDTH must be at least 1");
  end

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [RW-1:0]    r_q;
  logic [RW-1:0]    r_next;
  logic [CntW-1:0]  cnt_q;
  logic             ready_q;
  logic             res_q;
  logic             res_valid_q;
`ifdef MOD_SERIAL_REM_OUT_EN
  logic [RW-1:0]    rem_q;
`endif

  mod_serial_step #(
    .DIVISOR(DIVISOR),
    .RW     (RW)
  ) u_step (
    .r     (r_q),
    .b     (shreg_q[WIDTH-1]),
    .r_next(r_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      res_q       <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef MOD_SERIAL_REM_OUT_EN
      rem_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (src_valid) begin
            shreg_q <= src;
            r_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= StShift;
          end
        end
        StShift: begin
          shreg_q <= shreg_q << 1;
          r_q     <= r_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            res_q       <= (r_next == '0);
`ifdef MOD_SERIAL_REM_OUT_EN
            rem_q       <= r_next;
`endif
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          res_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          res_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;
`ifdef MOD_SERIAL_REM_OUT_EN
  assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_mod_serial.sv
// Scoreboard bench for mod_serial: default 32/7 instance plus an 8/3 instance.
module tb_mod_serial;

  typedef struct {
    bit r;
    int rem;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_a;
  logic        src_valid_a;
  logic        ready_a, res_a, res_valid_a;
  logic [7:0]  src_b;
  logic        src_valid_b;
  logic        ready_b, res_b, res_valid_b;
`ifdef MOD_SERIAL_REM_OUT_EN
  logic [2:0]  rem_a;
  logic [1:0]  rem_b;
`endif

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_serial #(
    .WIDTH  (32),
    .DIVISOR(7)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .src      (src_a),
    .src_valid(src_valid_a),
    .ready    (ready_a),
    .res      (res_a),
    .res_valid(res_valid_a)
`ifdef MOD_SERIAL_REM_OUT_EN
    ,
    .rem      (rem_a)
`endif
  );

  mod_serial #(
    .WIDTH  (8),
    .DIVISOR(3)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .src      (src_b),
    .src_valid(src_valid_b),
    .ready    (ready_b),
    .res      (res_b),
    .res_valid(res_valid_b)
`ifdef MOD_SERIAL_REM_OUT_EN
    ,
    .rem      (rem_b)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Offer an operand, wait for the accept edge and record what the result must be.
  task automatic send(input int which, input logic [31:0] v, input bit er, input int erem,
                      output int acc);
    int n = 0;
    exp_t e;
    @(negedge clk);
    if (which == 0) begin
      src_a = v;
      src_valid_a = 1'b1;
    end else begin
      src_b = v[7:0];
      src_valid_b = 1'b1;
    end
    while (!((which == 0) ? ready_a : ready_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      fails++;
      $display("FAIL ready_timeout: waited %0d cycles, ready still low", n);
      acc = -1;
      return;
    end
    @(negedge clk);
    acc   = cyc;
    e.r   = er;
    e.rem = erem;
    e.cyc = acc + ((which == 0) ? 32 : 8);
    if (which == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && res_valid_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        e = qa.pop_front();
        check("a_res", int'(res_a), int'(e.r));
`ifdef MOD_SERIAL_REM_OUT_EN
        check("a_rem", int'(rem_a), e.rem);
`endif
        check("a_latency", cyc, e.cyc);
        check("a_ready_with_valid", int'(ready_a), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && res_valid_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        e = qb.pop_front();
        check("b_res", int'(res_b), int'(e.r));
`ifdef MOD_SERIAL_REM_OUT_EN
        check("b_rem", int'(rem_b), e.rem);
`endif
        check("b_latency", cyc, e.cyc);
        check("b_ready_with_valid", int'(ready_b), 0);
      end
    end
  end

  initial begin
    int a0, a1, n;
    rst = 1'b0;
    src_a = '0;
    src_b = '0;
    src_valid_a = 1'b0;
    src_valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_a", int'(ready_a), 1);
    check("rst_res_a", int'(res_a), 0);
    check("rst_valid_a", int'(res_valid_a), 0);
    check("rst_ready_b", int'(ready_b), 1);
    check("rst_valid_b", int'(res_valid_b), 0);
`ifdef MOD_SERIAL_REM_OUT_EN
    check("rst_rem_a", int'(rem_a), 0);
`endif
    rst = 1'b1;

    // 7 is divisible; ready must be back exactly 33 cycles after accept.
    send(0, 32'd7, 1'b1, 0, a0);
    src_valid_a = 1'b0;
    repeat (32) @(negedge clk);
    check("a_ready_at_e32", int'(ready_a), 0);
    @(negedge clk);
    check("a_ready_at_e33", int'(ready_a), 1);

    // Abort mid-shift: outputs return to reset values at once, no result pulse.
    send(0, 32'd100, 1'b0, 2, a0);
    src_valid_a = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready", int'(ready_a), 1);
    check("abort_valid", int'(res_valid_a), 0);
    check("abort_res", int'(res_a), 0);
    qa.delete();
    @(negedge clk);
    rst = 1'b1;
    send(0, 32'd14, 1'b1, 0, a0);
    src_valid_a = 1'b0;

    // Changing src during SHIFT is ignored; 14 waits for the next idle cycle.
    send(0, 32'd15, 1'b0, 1, a0);
    @(negedge clk);
    send(0, 32'd14, 1'b1, 0, a1);
    check("a_spacing_15_14", a1 - a0, 34);
    src_valid_a = 1'b0;

    // Back-to-back operands with src_valid held high.
    send(0, 32'd0, 1'b1, 0, a0);
    send(0, 32'd896, 1'b1, 0, a1);
    check("a_spacing_0_896", a1 - a0, 34);
    send(0, 32'd165, 1'b0, 4, a0);
    check("a_spacing_896_165", a0 - a1, 34);
    src_valid_a = 1'b0;

    send(0, 32'hFFFF_FFFF, 1'b0, 3, a0);
    src_valid_a = 1'b0;

    // Narrow instance, divisor 3.
    send(1, 32'd255, 1'b1, 0, a0);
    send(1, 32'd1, 1'b0, 1, a1);
    check("b_spacing", a1 - a0, 10);
    send(1, 32'd128, 1'b0, 2, a0);
    send(1, 32'd85, 1'b0, 1, a0);
    send(1, 32'd170, 1'b0, 2, a0);
    src_valid_b = 1'b0;

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_pending", qa.size(), 0);
    check("b_pending", qb.size(), 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
